wb_master: RTL



---
 rtl/wb_master_pkg.sv | 20 ++
 rtl/wb_cmd_fifo.sv | 52 +++++
 rtl/wb_master.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone B4 classic command master: FSM states and the
// command record queued between the host stream and the bus.
package wb_master_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned ADDR_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO; dout always shows the head
// entry so the bus FSM can register it in the same cycle it pops.
module wb_cmd_fifo #(
  parameter int unsigned G_WIDTH = 10,
  parameter int unsigned G_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [G_WIDTH-1:0] i_din,
  output logic [G_WIDTH-1:0] o_dout,
  output logic               o_full,
  output logic               o_empty
);

  localparam int unsigned PW = $clog2(G_DEPTH);

  logic [G_WIDTH-1:0] mem_q [G_DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [PW:0]        count_q;
  logic               push_en;
  logic               pop_en;

  assign o_full  = (count_q == (PW+1)'(G_DEPTH));
  assign o_empty = (count_q == '0);
  assign push_en = i_push && !o_full;
  assign pop_en  = i_pop && !o_empty;
  assign o_dout  = mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_en) mem_q[wr_ptr_q] <= i_din;
  end

endmodule

// File: rtl/wb_master.sv
// Wishbone B4 classic single-cycle master: queues commands and issues them one
// at a time. Optional ack timeout is compiled in with WB_MASTER_TIMEOUT_EN.
module wb_master
  import wb_master_pkg::*;
#(
  parameter int unsigned G_WORD_WIDTH = WORD_W,
  parameter int unsigned G_ADDR_WIDTH = ADDR_W,
  parameter int unsigned G_FIFO_DEPTH = 4,
  parameter int unsigned G_TIMEOUT    = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_we,
  input  logic [G_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [G_WORD_WIDTH-1:0] i_cmd_data,
  output logic                    o_rsp_valid,
  output logic [G_WORD_WIDTH-1:0] o_rsp_data,
  output logic                    o_rsp_err,
  output logic                    o_cyc,
  output logic                    o_stb,
  output logic                    o_we,
  output logic [G_ADDR_WIDTH-1:0] o_addr,
  output logic [G_WORD_WIDTH-1:0] o_data,
  input  logic [G_WORD_WIDTH-1:0] i_data,
  input  logic                    i_ack,
  output logic                    o_busy
);

  localparam int unsigned CMD_W = 1 + G_ADDR_WIDTH + G_WORD_WIDTH;

  state_e                  state_q, state_d;
  logic                    stb_q, stb_d;
  logic                    we_q, we_d;
  logic [G_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [G_WORD_WIDTH-1:0] data_q, data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [G_WORD_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CMD_W-1:0]        fifo_dout;
  logic                    head_we;
  logic [G_ADDR_WIDTH-1:0] head_addr;
  logic [G_WORD_WIDTH-1:0] head_data;

  wb_cmd_fifo #(
    .G_WIDTH (CMD_W),
    .G_DEPTH (G_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_cmd_valid),
    .i_pop   (fifo_pop),
    .i_din   ({i_cmd_we, i_cmd_addr, i_cmd_data}),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign {head_we, head_addr, head_data} = fifo_dout;

  assign o_cmd_ready = !fifo_full;
  assign o_busy      = !fifo_empty || (state_q != IDLE);
  assign o_cyc       = stb_q;
  assign o_stb       = stb_q;
  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_data      = data_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(G_TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_err_q, rsp_err_d;

  assign o_rsp_err = rsp_err_q;
`else
  // Keeps the parameter referenced when the timeout is compiled out.
  logic unused_timeout;
  assign unused_timeout = ^G_TIMEOUT;
  assign o_rsp_err      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    fifo_pop    = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_d       = tmo_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = head_we;
          addr_d   = head_addr;
          data_d   = head_data;
          stb_d    = 1'b1;
          state_d  = ACTIVE;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end
      end
      ACTIVE: begin
        // Ack is tested first so it wins over a timeout firing in the same cycle.
        if (i_ack) begin
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? '0 : i_data;
          state_d     = GAP;
`ifdef WB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
        end else if (tmo_q == TW'(G_TIMEOUT)) begin
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          state_d     = GAP;
        end else begin
          tmo_d       = tmo_q + 1'b1;
`endif
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q       <= tmo_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

endmodule
